ibex_rvfi_trace_buffer: RTL and testbench

Retirement trace buffer downstream of the tracing core top.
- Consumes the RVFI retirement stream, one record per cycle when rvfi_valid_i is high.
- Stores selected fields in a first-word-fall-through circular FIFO.
- Drains the FIFO over a valid/ready stream to a debug or trace-export port.
- Supports capture enable, freeze-on-trap for post-mortem capture, and a saturating drop counter for records lost on overflow.

---
 rtl/ibex_rvfi_trace_buffer.sv | 153 +++++++++++++++
 tb/tb_ibex_rvfi_trace_buffer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_rvfi_trace_buffer.sv
// RVFI retirement trace buffer: FWFT circular FIFO with capture FSM, freeze-on-trap and saturating drop counter.
// Optional per-entry memory fields are enabled by defining RVFI_TRACE_BUF_MEM_EN.
module ibex_rvfi_trace_buffer #(
    parameter int unsigned Depth        = 16,
    parameter int unsigned DropCntWidth = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       enable_i,
    input  logic                       stop_on_trap_i,
    input  logic                       clear_i,
    input  logic                       rvfi_valid_i,
    input  logic [63:0]                rvfi_order_i,
    input  logic [31:0]                rvfi_insn_i,
    input  logic                       rvfi_trap_i,
    input  logic [31:0]                rvfi_pc_rdata_i,
    input  logic [4:0]                 rvfi_rd_addr_i,
    input  logic [31:0]                rvfi_rd_wdata_i,
`ifdef RVFI_TRACE_BUF_MEM_EN
    input  logic [31:0]                rvfi_mem_addr_i,
    input  logic [3:0]                 rvfi_mem_rmask_i,
    input  logic [3:0]                 rvfi_mem_wmask_i,
    input  logic [31:0]                rvfi_mem_rdata_i,
    input  logic [31:0]                rvfi_mem_wdata_i,
    output logic [31:0]                trace_mem_addr_o,
    output logic [3:0]                 trace_mem_rmask_o,
    output logic [3:0]                 trace_mem_wmask_o,
    output logic [31:0]                trace_mem_rdata_o,
    output logic [31:0]                trace_mem_wdata_o,
`endif
    output logic                       trace_valid_o,
    input  logic                       trace_ready_i,
    output logic [31:0]                trace_order_o,
    output logic [31:0]                trace_pc_o,
    output logic [31:0]                trace_insn_o,
    output logic [4:0]                 trace_rd_addr_o,
    output logic [31:0]                trace_rd_wdata_o,
    output logic                       trace_trap_o,
    output logic [$clog2(Depth):0]     level_o,
    output logic [DropCntWidth-1:0]    drop_count_o,
    output logic                       frozen_o,
    output logic [1:0]                 state_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned LW = AW + 1;
`ifdef RVFI_TRACE_BUF_MEM_EN
    localparam int unsigned EW = 134 + 104;
`else
    localparam int unsigned EW = 134;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FROZEN  = 2'd2
    } state_e;

    // Handshake: a record moves to the consumer on a cycle where trace_valid_o
    // and trace_ready_i are both high; trace_valid_o never depends on trace_ready_i.
    state_e                  r_state;
    state_e                  w_state_next;
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [LW-1:0]           r_level;
    logic [DropCntWidth-1:0] r_drop;
    logic [EW-1:0]           r_mem [Depth];

    logic                    w_capture;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;
    logic                    w_full;
    logic [EW-1:0]           w_wr_entry;
    logic [EW-1:0]           w_head;

    assign w_full    = (r_level == LW'(Depth));
    assign w_capture = rvfi_valid_i && (r_state == ST_CAPTURE) && !clear_i;
    assign w_pop     = trace_valid_o && trace_ready_i && !clear_i;
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_drop    = w_capture && !w_push;

`ifdef RVFI_TRACE_BUF_MEM_EN
    assign w_wr_entry = {rvfi_order_i[31:0], rvfi_pc_rdata_i, rvfi_insn_i, rvfi_rd_addr_i,
                         rvfi_rd_wdata_i, rvfi_trap_i, rvfi_mem_addr_i, rvfi_mem_rmask_i,
                         rvfi_mem_wmask_i, rvfi_mem_rdata_i, rvfi_mem_wdata_i};
    assign {trace_order_o, trace_pc_o, trace_insn_o, trace_rd_addr_o, trace_rd_wdata_o,
            trace_trap_o, trace_mem_addr_o, trace_mem_rmask_o, trace_mem_wmask_o,
            trace_mem_rdata_o, trace_mem_wdata_o} = w_head;
`else
    assign w_wr_entry = {rvfi_order_i[31:0], rvfi_pc_rdata_i, rvfi_insn_i, rvfi_rd_addr_i,
                         rvfi_rd_wdata_i, rvfi_trap_i};
    assign {trace_order_o, trace_pc_o, trace_insn_o, trace_rd_addr_o, trace_rd_wdata_o,
            trace_trap_o} = w_head;
`endif

    // Storage is not reset; the head is masked to zero whenever the FIFO is empty.
    assign trace_valid_o = (r_level != '0);
    assign w_head        = trace_valid_o ? r_mem[r_rd_ptr] : '0;
    assign level_o       = r_level;
    assign drop_count_o  = r_drop;
    assign frozen_o      = (r_state == ST_FROZEN);
    assign state_o       = r_state;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable_i) w_state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (rvfi_valid_i && rvfi_trap_i && stop_on_trap_i) w_state_next = ST_FROZEN;
                else if (!enable_i)                                  w_state_next = ST_IDLE;
            end
            ST_FROZEN: w_state_next = ST_FROZEN;
            default:   w_state_next = ST_IDLE;
        endcase
        if (clear_i) w_state_next = ST_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_drop   <= '0;
        end else begin
            r_state <= w_state_next;
            if (clear_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
                r_drop   <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + LW'(1);
                    2'b01:   r_level <= r_level - LW'(1);
                    default: r_level <= r_level;
                endcase
                if (w_drop && (r_drop != '1)) r_drop <= r_drop + DropCntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= w_wr_entry;
    end

endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
// Scoreboard bench for ibex_rvfi_trace_buffer: directed retirement vectors, expected records queued, monitor compares drained records.
module tb_ibex_rvfi_trace_buffer;
  localparam int W = 134;
  localparam logic [1:0] S_IDLE = 2'd0, S_CAP = 2'd1, S_FRZ = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable, stop_on_trap, clear;
  logic        rvfi_valid, rvfi_trap;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn, rvfi_pc, rvfi_wdata;
  logic [4:0]  rvfi_rd;
  logic        trace_valid, trace_ready, trace_trap;
  logic [31:0] trace_order, trace_pc, trace_insn, trace_wdata;
  logic [4:0]  trace_rd;
  logic [4:0]  level;
  logic [3:0]  drop_count;
  logic        frozen;
  logic [1:0]  state;
`ifdef RVFI_TRACE_BUF_MEM_EN
  logic [31:0] mem_addr_o, mem_rdata_o, mem_wdata_o;
  logic [3:0]  mem_rmask_o, mem_wmask_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  logic [31:0]  ord_cnt = 32'd0;

  always #5 clk = ~clk;

  ibex_rvfi_trace_buffer #(.Depth(16), .DropCntWidth(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .stop_on_trap_i(stop_on_trap),
    .clear_i(clear), .rvfi_valid_i(rvfi_valid), .rvfi_order_i(rvfi_order),
    .rvfi_insn_i(rvfi_insn), .rvfi_trap_i(rvfi_trap), .rvfi_pc_rdata_i(rvfi_pc),
    .rvfi_rd_addr_i(rvfi_rd), .rvfi_rd_wdata_i(rvfi_wdata),
`ifdef RVFI_TRACE_BUF_MEM_EN
    .rvfi_mem_addr_i(32'h0), .rvfi_mem_rmask_i(4'h0), .rvfi_mem_wmask_i(4'h0),
    .rvfi_mem_rdata_i(32'h0), .rvfi_mem_wdata_i(32'h0),
    .trace_mem_addr_o(mem_addr_o), .trace_mem_rmask_o(mem_rmask_o),
    .trace_mem_wmask_o(mem_wmask_o), .trace_mem_rdata_o(mem_rdata_o),
    .trace_mem_wdata_o(mem_wdata_o),
`endif
    .trace_valid_o(trace_valid), .trace_ready_i(trace_ready), .trace_order_o(trace_order),
    .trace_pc_o(trace_pc), .trace_insn_o(trace_insn), .trace_rd_addr_o(trace_rd),
    .trace_rd_wdata_o(trace_wdata), .trace_trap_o(trace_trap), .level_o(level),
    .drop_count_o(drop_count), .frozen_o(frozen), .state_o(state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one retirement record for one cycle; accept says whether it must reach the consumer.
  task automatic drive_rec(input logic [31:0] pc, input logic trap, input logic accept);
    rvfi_valid = 1'b1;
    rvfi_order = {32'hA5A5_0000, ord_cnt};
    rvfi_pc    = pc;
    rvfi_insn  = {pc[15:0], 16'h0013};
    rvfi_rd    = pc[6:2];
    rvfi_wdata = ~pc;
    rvfi_trap  = trap;
    if (accept) exp_q.push_back({ord_cnt, pc, pc[15:0], 16'h0013, pc[6:2], ~pc, trap});
    ord_cnt++;
    step();
  endtask

  task automatic drain(input int budget);
    trace_ready = 1'b1;
    for (int i = 0; i < budget && trace_valid; i++) step();
    trace_ready = 1'b0;
    check("drain_done", trace_valid, 0);
  endtask

  // Monitor: every record the consumer takes is compared against the queue head.
  always @(negedge clk) begin
    if (rst_n && trace_valid && trace_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL trace_unexpected: got pc 0x%0h expected none", trace_pc);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({trace_order, trace_pc, trace_insn, trace_rd, trace_wdata, trace_trap} !== mon_exp) begin
          errors++;
          $display("FAIL trace_rec: got 0x%0h expected 0x%0h",
                   {trace_order, trace_pc, trace_insn, trace_rd, trace_wdata, trace_trap}, mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    enable = 0; stop_on_trap = 0; clear = 0; trace_ready = 0;
    rvfi_valid = 0; rvfi_trap = 0; rvfi_order = '0; rvfi_insn = '0;
    rvfi_pc = '0; rvfi_rd = '0; rvfi_wdata = '0;
    repeat (3) step();
    check("rst_level", level, 0);
    check("rst_valid", trace_valid, 0);
    check("rst_pc", trace_pc, 0);
    check("rst_order", trace_order, 0);
    check("rst_drop", drop_count, 0);
    check("rst_frozen", frozen, 0);
    check("rst_state", state, S_IDLE);
    rst_n = 1'b1;
    enable = 1'b1;
    trace_ready = 1'b1;
    step();
    check("state_capture", state, S_CAP);

    // Three records streamed with the consumer always ready.
    drive_rec(32'h100, 1'b0, 1'b1);
    check("lat_valid", trace_valid, 1);
    check("lat_pc0", trace_pc, 32'h100);
    drive_rec(32'h104, 1'b0, 1'b1);
    check("lat_pc1", trace_pc, 32'h104);
    drive_rec(32'h108, 1'b1, 1'b1);
    check("lat_pc2", trace_pc, 32'h108);
    check("trap_no_freeze", frozen, 0);
    rvfi_valid = 1'b0;
    step();
    check("t1_level", level, 0);
    check("t1_empty_pc", trace_pc, 0);
    check("t1_drop", drop_count, 0);
    check("t1_state", state, S_CAP);

    // Overflow: 20 records into a 16-deep FIFO with the consumer stalled.
    trace_ready = 1'b0;
    for (int i = 0; i < 20; i++) drive_rec(32'h300 + 32'(i * 4), 1'b0, i < 16);
    rvfi_valid = 1'b0;
    step();
    check("ovf_level", level, 16);
    check("ovf_drop", drop_count, 4);
    check("ovf_head_pc", trace_pc, 32'h300);

    // Full FIFO with pop and push in the same cycle.
    trace_ready = 1'b1;
    drive_rec(32'h400, 1'b0, 1'b1);
    trace_ready = 1'b0;
    rvfi_valid = 1'b0;
    check("fullpop_level", level, 16);
    check("fullpop_drop", drop_count, 4);
    check("fullpop_head", trace_pc, 32'h304);
    drain(40);

    // Drop counter saturation at 4'hF.
    for (int i = 0; i < 26; i++) drive_rec(32'h600 + 32'(i * 4), 1'b0, i < 16);
    check("sat_before", drop_count, 14);
    for (int i = 0; i < 10; i++) drive_rec(32'h700 + 32'(i * 4), 1'b0, 1'b0);
    rvfi_valid = 1'b0;
    check("sat_drop", drop_count, 15);
    check("sat_level", level, 16);

    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_q.delete();
    check("clr1_level", level, 0);
    check("clr1_drop", drop_count, 0);
    check("clr1_state", state, S_IDLE);
    step();
    check("clr1_resume", state, S_CAP);

    // Freeze on trap with entries and drops pending.
    stop_on_trap = 1'b1;
    for (int i = 0; i < 19; i++) drive_rec(32'h800 + 32'(i * 4), 1'b0, i < 16);
    rvfi_valid = 1'b0;
    trace_ready = 1'b1;
    repeat (12) step();
    trace_ready = 1'b0;
    check("pre_frz_level", level, 4);
    drive_rec(32'h200, 1'b1, 1'b1);
    check("frz_frozen", frozen, 1);
    check("frz_level", level, 5);
    drive_rec(32'h204, 1'b0, 1'b0);
    rvfi_valid = 1'b0;
    check("frz_ignore_level", level, 5);
    check("frz_drop", drop_count, 3);
    enable = 1'b0;
    step();
    check("frz_enable_ignored", state, S_FRZ);
    enable = 1'b1;
    trace_ready = 1'b1;
    step();
    trace_ready = 1'b0;
    check("frz_drain_level", level, 4);

    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_q.delete();
    check("clr2_level", level, 0);
    check("clr2_drop", drop_count, 0);
    check("clr2_frozen", frozen, 0);
    check("clr2_valid", trace_valid, 0);
    drive_rec(32'h500, 1'b0, 1'b0);
    check("idle_ignore", level, 0);
    drive_rec(32'h504, 1'b0, 1'b1);
    rvfi_valid = 1'b0;
    check("resume_level", level, 1);
    check("resume_pc", trace_pc, 32'h504);
    drain(5);

    // Disabling capture returns to IDLE; records are then ignored, not dropped.
    enable = 1'b0;
    step();
    check("disable_state", state, S_IDLE);
    drive_rec(32'h900, 1'b0, 1'b0);
    rvfi_valid = 1'b0;
    check("disable_level", level, 0);
    check("disable_drop", drop_count, 0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
